div_monitor: RTL and testbench
==============================

# div_monitor

Downstream checker for the frequency divider's two divided outputs (y1, y2). It samples both outputs in the divider's clock domain, detects rising edges and measures each output's period in clk cycles. It also compares every measurement against the expected ratio and reports lock or a sticky fault. It sits directly after the divider and gives the system, and the bench, a self-checking health signal for the divided clocks.

## Interface
- EXP1, 2, expected y1 period in clk cycles (≥2)
- EXP2, 4, expected y2 period in clk cycles (≥2, integer multiple of EXP1)
- CNT_W, 8, period counter width
- LOCK_COUNT, 4, consecutive good measurement cycles required for lock
- clk  in  1  system clock, same clock that drives the divider
- rst  in  1  synchronous, active-high reset
- y1_in  in  1  divider output 1, synchronous to clk
- y2_in  in  1  divider output 2, synchronous to clk
- clr  in  1  one-cycle request to leave FAULT and re-acquire
- edge1, edge2  out  1  one-cycle pulse per detected rising edge
- period1, period2  out  CNT_W  last measured period per channel
- lock  out  1  high while state is LOCKED
- fault  out  1  high while state is FAULT
- phase_err  out  1  one-cycle pulse on a ratio violation (only with macro)

## Operation
- Per channel:
  - y_q <= y_in. rise = y_in & ~y_q.
  - On rise: periodN <= cnt, cnt <= 1, edgeN <= 1.
  - Otherwise: cnt <= cnt+1, saturating at all-ones.
  - Measurement events:
    - The first rise after reset or clr only arms the channel and is not a measurement.
    - Every later rise is a measurement.
    - cnt reaching all-ones is a timeout event and counts as a mismatch.
- A measurement on channel N is good when period equals EXPN. Otherwise it is a mismatch.
- Per cycle: bad = any mismatch or timeout (or phase violation). good = at least one measurement and not bad. Bad wins over good in the same cycle.
- State machine, reset state IDLE:
  - IDLE: good_cnt=0. Moves to ACQUIRE when both channels are armed.
  - ACQUIRE:
    - On good, good_cnt++.
    - On bad, good_cnt <= 0 and stay in ACQUIRE.
    - Moves to LOCKED when good_cnt reaches LOCK_COUNT.
  - LOCKED: on bad, move to FAULT.
  - FAULT: sticky. Only clr or rst leaves it.
- clr in any state moves to IDLE, disarms both channels, and zeroes cnt and good_cnt. periodN is held. rst wins over clr.
- lock and fault decode the state register directly.

## Timing
- All outputs are registered.
- Reset values: edge1 = edge2 = 0, period1 = period2 = 0, lock = 0, fault = 0, phase_err = 0. Also cnt = 0, good_cnt = 0, channels disarmed.
- Latency: a rise sampled at cycle t produces edgeN and the updated periodN at cycle t+1.
- lock and fault change at t+1 relative to the deciding event.
- A constant period P gives periodN = P.
- Simultaneous rises on both channels are evaluated in the same cycle.
- rst asserted mid-operation returns every output to its reset value on the next cycle.

## Configuration
- DIV_MONITOR_PHASE_CHECK_EN defined:
  - An extra counter counts y1 measurement rises between consecutive y2 rises.
  - At each y2 measurement, the count must equal EXP2/EXP1. If not, phase_err pulses for one cycle at t+1 and the cycle is bad.
  - The count restarts at every y2 rise.
- Undefined: no phase counter and no phase_err port. Behaviour is otherwise identical.

## Structure
- Package div_monitor_pkg holds:
  - the state enum (IDLE, ACQUIRE, LOCKED, FAULT)
  - the default CNT_W
  - the saturating-max constant function
- Sub-module div_monitor_chan contains the edge detector, saturating period counter, armed flag, edge pulse and period register. It is instantiated once per channel.
- Top level contains the comparisons, good_cnt, FSM and optional phase counter.

## Test plan
All scenarios use the default parameters.

1. Reset and lock:
   - Stimulus: rst high 2 cycles, then y1 period 2 and y2 period 4 in phase.
   - Required response: all outputs 0 during reset. period1=2 and period2=4. lock=1 within 16 cycles of rst release. fault=0 throughout.
2. Period fault:
   - Stimulus: after lock, stretch one y2 period to 6.
   - Required response: period2=6, lock=0, fault=1 one cycle after that rise. fault stays 1 for 20 more cycles of ideal input.
3. Recovery:
   - Stimulus: pulse clr in FAULT.
   - Required response: fault=0 next cycle, state IDLE. lock returns within 16 cycles. period registers keep their old values until the next measurement.
4. Timeout:
   - Stimulus: hold y1_in low after lock.
   - Required response: fault=1 once cnt1 saturates at 255.
5. Ratio check:
   - Stimulus: y2 period 4, y1 period 4.
   - Required response, macro defined: phase_err pulses at each y2 measurement and lock is never reached.
   - Required response, macro undefined: only period1 mismatches keep lock low.
6. Reset mid-lock:
   - Stimulus: assert rst for 1 cycle while LOCKED.
   - Required response: next cycle lock=0 and period1=period2=0. Re-lock follows normally.

Source files
------------

// File: rtl/div_monitor_pkg.sv
// Shared types and helpers for the divided-clock health monitor.
// Optional ratio checking is enabled with DIV_MONITOR_PHASE_CHECK_EN.
package div_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED,
        FAULT
    } state_t;

    localparam int DEF_CNT_W = 8;

    function automatic logic [31:0] sat_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/div_monitor_chan.sv
// One monitored channel: rise detect, saturating period counter,
// armed flag, edge pulse and last-measured-period register.
module div_monitor_chan
    import div_monitor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             y_in,
    output logic             meas,
    output logic             timeout,
    output logic             armed,
    output logic [CNT_W-1:0] cnt,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] period
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(sat_max(CNT_W));

    logic y_q;
    logic rise;

    assign rise    = y_in & ~y_q;
    assign meas    = rise & armed;
    assign timeout = armed & (cnt == MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q        <= 1'b0;
            cnt        <= '0;
            armed      <= 1'b0;
            edge_pulse <= 1'b0;
            period     <= '0;
        end else begin
            y_q <= y_in;
            if (clr) begin
                cnt        <= '0;
                armed      <= 1'b0;
                edge_pulse <= 1'b0;
            end else if (rise) begin
                // the arming rise is not a measurement, so period is kept
                if (armed)
                    period <= cnt;
                cnt        <= CNT_W'(1);
                armed      <= 1'b1;
                edge_pulse <= 1'b1;
            end else begin
                edge_pulse <= 1'b0;
                if (cnt != MAX)
                    cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/div_monitor.sv
// Divider output checker: measures y1/y2 periods and tracks lock/fault.
// Define DIV_MONITOR_PHASE_CHECK_EN to add the y2/y1 ratio check.
module div_monitor
    import div_monitor_pkg::*;
#(
    parameter int EXP1       = 2,
    parameter int EXP2       = 4,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y1_in,
    input  logic             y2_in,
    input  logic             clr,
    output logic             edge1,
    output logic             edge2,
    output logic [CNT_W-1:0] period1,
    output logic [CNT_W-1:0] period2,
    output logic             lock,
    output logic             fault
`ifdef DIV_MONITOR_PHASE_CHECK_EN
    ,
    output logic             phase_err
`endif
);

    localparam int GC_W = $clog2(LOCK_COUNT + 1);

    logic             meas1, meas2;
    logic             tout1, tout2;
    logic             armed1, armed2;
    logic [CNT_W-1:0] cnt1, cnt2;
    logic             mism1, mism2;
    logic             ph_bad;
    logic             bad, good;

    state_t           state, state_n;
    logic [GC_W-1:0]  good_cnt, good_cnt_n;

    div_monitor_chan #(.CNT_W(CNT_W)) u_chan1 (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .y_in       (y1_in),
        .meas       (meas1),
        .timeout    (tout1),
        .armed      (armed1),
        .cnt        (cnt1),
        .edge_pulse (edge1),
        .period     (period1)
    );

    div_monitor_chan #(.CNT_W(CNT_W)) u_chan2 (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .y_in       (y2_in),
        .meas       (meas2),
        .timeout    (tout2),
        .armed      (armed2),
        .cnt        (cnt2),
        .edge_pulse (edge2),
        .period     (period2)
    );

    assign mism1 = meas1 & (cnt1 != CNT_W'(EXP1));
    assign mism2 = meas2 & (cnt2 != CNT_W'(EXP2));

`ifdef DIV_MONITOR_PHASE_CHECK_EN
    localparam logic [CNT_W-1:0] RATIO = CNT_W'(EXP2 / EXP1);
    localparam logic [CNT_W-1:0] PMAX  = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] ph_cnt;
    logic [CNT_W-1:0] ph_now;

    // a y1 rise coinciding with a y2 rise closes the current interval
    assign ph_now = (meas1 && ph_cnt != PMAX) ? ph_cnt + CNT_W'(1) : ph_cnt;
    assign ph_bad = meas2 & (ph_now != RATIO);

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_cnt    <= '0;
            phase_err <= 1'b0;
        end else begin
            phase_err <= ph_bad & ~clr;
            if (clr || meas2 || !armed2)
                ph_cnt <= '0;
            else
                ph_cnt <= ph_now;
        end
    end
`else
    assign ph_bad = 1'b0;
`endif

    assign bad  = mism1 | mism2 | tout1 | tout2 | ph_bad;
    assign good = (meas1 | meas2) & ~bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            good_cnt <= '0;
        end else begin
            state    <= state_n;
            good_cnt <= good_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        good_cnt_n = good_cnt;
        if (clr) begin
            state_n    = IDLE;
            good_cnt_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    good_cnt_n = '0;
                    if (armed1 && armed2)
                        state_n = ACQUIRE;
                end
                ACQUIRE: begin
                    if (bad) begin
                        good_cnt_n = '0;
                    end else if (good) begin
                        good_cnt_n = good_cnt + GC_W'(1);
                        if (good_cnt == GC_W'(LOCK_COUNT - 1))
                            state_n = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bad)
                        state_n = FAULT;
                end
                FAULT: begin
                    state_n = FAULT;
                end
            endcase
        end
    end

    assign lock  = (state == LOCKED);
    assign fault = (state == FAULT);

endmodule

// File: tb/tb_div_monitor.sv
// Directed bench for div_monitor with a period scoreboard per channel.
// Phase-error checks are compiled in with DIV_MONITOR_PHASE_CHECK_EN.
module tb_div_monitor;

    logic       clk = 1'b0;
    logic       rst, clr, y1_in, y2_in;
    logic       edge1, edge2, lock, fault;
    logic [7:0] period1, period2;
`ifdef DIV_MONITOR_PHASE_CHECK_EN
    logic       phase_err;
`endif

    div_monitor dut (
        .clk     (clk),
        .rst     (rst),
        .y1_in   (y1_in),
        .y2_in   (y2_in),
        .clr     (clr),
        .edge1   (edge1),
        .edge2   (edge2),
        .period1 (period1),
        .period2 (period2),
        .lock    (lock),
        .fault   (fault)
`ifdef DIV_MONITOR_PHASE_CHECK_EN
        ,
        .phase_err (phase_err)
`endif
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    int q1[$];
    int q2[$];
    int p1, p2, c1, c2, cyc;
    int last1, last2, exp1, exp2;
    bit hold1, py1, py2, arm1, arm2, m1, m2;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        arm1 = 0; arm2 = 0; py1 = 0; py2 = 0;
        c1 = 0; c2 = 0; hold1 = 0; m1 = 0; m2 = 0;
    endtask

    task automatic tick();
        bit y1, y2, r1, r2;
        y1 = !hold1 && (c1 < p1 / 2);
        y2 = (c2 < p2 / 2);
        r1 = y1 && !py1;
        r2 = y2 && !py2;
        py1 = y1;
        py2 = y2;
        m1 = r1 && arm1;
        m2 = r2 && arm2;
        if (r1) begin
            if (arm1) exp1 = (cyc - last1 > 255) ? 255 : cyc - last1;
            arm1 = 1; last1 = cyc;
            q1.push_back(exp1);
        end
        if (r2) begin
            if (arm2) exp2 = (cyc - last2 > 255) ? 255 : cyc - last2;
            arm2 = 1; last2 = cyc;
            q2.push_back(exp2);
        end
        y1_in = y1;
        y2_in = y2;
        @(posedge clk); #1; cyc++;
        check("edge1", edge1, r1);
        check("edge2", edge2, r2);
        if (edge1 && q1.size() > 0) check("period1", period1, q1.pop_front());
        if (edge2 && q2.size() > 0) check("period2", period2, q2.pop_front());
        if (!hold1) c1 = (c1 + 1) % p1;
        c2 = (c2 + 1) % p2;
    endtask

    task automatic do_reset(input int n);
        rst = 1; clr = 0; y1_in = 0; y2_in = 0;
        repeat (n) begin
            @(posedge clk); #1; cyc++;
            check("rst_edge1", edge1, 0);
            check("rst_edge2", edge2, 0);
            check("rst_period1", period1, 0);
            check("rst_period2", period2, 0);
            check("rst_lock", lock, 0);
            check("rst_fault", fault, 0);
`ifdef DIV_MONITOR_PHASE_CHECK_EN
            check("rst_phase_err", phase_err, 0);
`endif
        end
        rst = 0;
        exp1 = 0; exp2 = 0;
        q1.delete(); q2.delete();
        model_reset();
    endtask

    task automatic wait_lock(input string tag);
        int n = 0;
        while (lock !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        check(tag, lock, 1);
    endtask

    initial begin
        int n;
        rst = 1; clr = 0; y1_in = 0; y2_in = 0;
        cyc = 0; p1 = 2; p2 = 4;
        model_reset();

        // reset and lock
        do_reset(2);
        wait_lock("t1_lock");
        check("t1_fault", fault, 0);
        check("t1_period1", period1, 2);
        check("t1_period2", period2, 4);

        // one stretched y2 period
        while (c2 != 0) tick();
        tick();
        check("t2_pre_lock", lock, 1);
        while (c2 != 0) tick();
        p2 = 6;
        repeat (6) tick();
        p2 = 4;
        tick();
        check("t2_period2", period2, 6);
        check("t2_lock", lock, 0);
        check("t2_fault", fault, 1);
        repeat (20) tick();
        check("t2_sticky", fault, 1);
        check("t2_sticky_lock", lock, 0);

        // clear and re-acquire
        clr = 1; y1_in = 0; y2_in = 0;
        @(posedge clk); #1; cyc++;
        clr = 0;
        model_reset();
        check("t3_fault", fault, 0);
        check("t3_lock", lock, 0);
        check("t3_hold1", period1, exp1);
        check("t3_hold2", period2, exp2);
        tick();
        check("t3_arm_hold1", period1, exp1);
        check("t3_arm_hold2", period2, exp2);
        wait_lock("t3_relock");

        // y1 stuck low
        hold1 = 1;
        n = 0;
        while (fault !== 1'b1 && n < 300) begin
            tick();
            n++;
`ifndef DIV_MONITOR_PHASE_CHECK_EN
            if (n == 200) check("t4_early", fault, 0);
`endif
        end
        check("t4_fault", fault, 1);
`ifndef DIV_MONITOR_PHASE_CHECK_EN
        check("t4_when", (n >= 250 && n <= 260), 1);
`endif

        // wrong ratio: y1 period equals y2 period
        do_reset(2);
        p1 = 4; p2 = 4;
        repeat (40) begin
            tick();
            check("t5_lock", lock, 0);
`ifdef DIV_MONITOR_PHASE_CHECK_EN
            check("t5_phase_err", phase_err, m2);
`endif
        end
        check("t5_period1", period1, 4);
        check("t5_drain", q1.size() + q2.size(), 0);

        // reset while locked
        do_reset(2);
        p1 = 2; p2 = 4;
        wait_lock("t6_lock");
        do_reset(1);
        wait_lock("t6_relock");
        check("t6_fault", fault, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
